// File: rtl/disp_pkg.sv
// Shared types and constants for the BCD converter / multiplexed 7-segment scanner.
// Segment patterns are active-low, bit 0 = segment a .. bit 6 = segment g.
package disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int          NUM_DIGITS = 4;
   localparam int          BIN_W      = 14;
   localparam logic [13:0] MAX_VAL    = 14'd9999;
   localparam logic [3:0]  LAST_BIT   = 4'd13;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Double-dabble correction: any digit >= 5 gets +3 so the following shift carries correctly.
   function automatic logic [15:0] bcd_adjust(input logic [15:0] w);
      logic [15:0] r;
      r = w;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD code to active-low seven-segment pattern; codes 10-15 blank the digit.
module seg7_decode
   import disp_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// 14-bit binary to 4-digit BCD converter (shift-add-3) driving a multiplexed 7-segment display.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
//
// Handshake: load is sampled every rising edge but only accepted while busy=0 (FSM idle);
// busy stays high from the edge after acceptance until the display update, and done pulses
// for exactly one cycle when the new digits become visible. Loads seen while busy are dropped.
module bcd_scan_ctrl
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] bin,
   input  logic        load,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output state_e      dbg_state
);

   localparam int             PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(REFRESH_DIV - 1);

   state_e        state_q, state_d;
   logic [13:0]   bin_q, bin_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [15:0]   work_q, work_d;
   logic [15:0]   disp_q, disp_d;
   logic          ovf_q, ovf_d;
   logic          done_q, done_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;

   logic [15:0]   work_adj;
   logic [3:0]    digit_cur;
   logic [3:0]    code_cur;

   assign work_adj = bcd_adjust(work_q);

   // Conversion FSM: next state, datapath updates and the done pulse.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               bin_d   = (bin > MAX_VAL) ? MAX_VAL : bin;
               ovf_d   = (bin > MAX_VAL);
               work_d  = '0;
               cnt_d   = LAST_BIT;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            work_d = {work_adj[14:0], bin_q[cnt_q]};
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            disp_d  = work_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Free-running refresh: one digit slot per REFRESH_DIV clocks.
   always_comb begin
      presc_d = presc_q;
      idx_d   = idx_q;
      if (presc_q == PRESC_MAX) begin
         presc_d = '0;
         idx_d   = idx_q + 2'd1;
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         cnt_q   <= '0;
         work_q  <= '0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         presc_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end

   assign digit_cur = disp_q[4*idx_q +: 4];

`ifdef DISP_LZB_EN
   // A digit is blanked only when it and every digit above it are zero; units always show.
   logic [3:0] blank;
   always_comb begin
      blank    = 4'b0000;
      blank[3] = (disp_q[15:12] == 4'd0);
      blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
      blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
      blank[0] = 1'b0;
      code_cur = blank[idx_q] ? 4'hF : digit_cur;
   end
`else
   assign code_cur = digit_cur;
`endif

   seg7_decode u_seg7_decode (
      .code (code_cur),
      .seg  (seg)
   );

   assign an        = ~(4'b0001 << idx_q);
   assign dp        = 1'b1;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign ovf       = ovf_q;
   assign dbg_state = state_q;

endmodule
